instr_cache_dm: RTL and testbench

Direct-mapped, read-only instruction cache. Replaces the flat instruction ROM in the fetch path with a tagged store that refills whole lines from backing memory on a miss. Sits between the fetch stage (request/response handshake) and the instruction memory port (single-outstanding word reads). Parametrised in address width, set count and line size. Supports whole-cache invalidate.

---
 rtl/instr_cache_dm.sv | 183 ++++++++++++++++++
 tb/tb_instr_cache_dm.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_cache_dm.sv
`default_nettype none
// ============================================================================
// Module   : instr_cache_dm
// Brief    : Direct-mapped read-only instruction cache with whole-line refill
//            and whole-cache invalidate. Optional hit/miss counters are built
//            when ICACHE_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module instr_cache_dm #(
   parameter int ADDR_W     = 32,
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   output logic              req_ready_o,
   output logic              rsp_valid_o,
   output logic [31:0]       rsp_data_o,
   input  logic              flush_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_valid_i,
   input  logic [31:0]       mem_data_i
`ifdef ICACHE_PERF_EN
  ,output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);

   localparam int c_off_w = $clog2(LINE_WORDS);
   localparam int c_idx_w = $clog2(SETS);
   localparam int c_tag_w = ADDR_W - c_idx_w - c_off_w - 2;
   localparam logic [c_off_w-1:0] c_last = c_off_w'(LINE_WORDS - 1);

   localparam logic [1:0] c_idle   = 2'd0;
   localparam logic [1:0] c_lookup = 2'd1;
   localparam logic [1:0] c_refill = 2'd2;
   localparam logic [1:0] c_resp   = 2'd3;

   logic [1:0]          r_state;
   logic [1:0]          w_next;
   logic [ADDR_W-3:0]   r_addr;
   logic [c_off_w-1:0]  r_cnt;
   logic                r_flush_pend;
   logic [SETS-1:0]     r_valid;
   logic [c_tag_w-1:0]  r_tag  [SETS];
   logic [31:0]         r_data [SETS*LINE_WORDS];

   logic [c_off_w-1:0]  w_off;
   logic [c_idx_w-1:0]  w_idx;
   logic [c_tag_w-1:0]  w_tag;
   logic                w_hit;
   logic                w_in_lookup;
   logic                w_accept;
   logic                w_mem_done;
   logic                w_last;
   logic                w_flush_clr;
   logic                w_unused;

   // Byte-lane bits of the fetch address carry no information for word fetches.
   assign w_unused    = ^req_addr_i[1:0];

   assign w_off       = r_addr[c_off_w-1:0];
   assign w_idx       = r_addr[c_off_w +: c_idx_w];
   assign w_tag       = r_addr[ADDR_W-3 -: c_tag_w];
   assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_in_lookup = (r_state == c_lookup);
   assign w_accept    = req_valid_i && req_ready_o;
   assign w_mem_done  = (r_state == c_refill) && mem_valid_i;
   assign w_last      = w_mem_done && (r_cnt == c_last);

   // A flush seen during refill/response waits until the line is delivered.
   assign w_flush_clr = (((r_state == c_idle) || w_in_lookup) && flush_i) ||
                        ((r_state == c_resp) && (flush_i || r_flush_pend));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_idle:   if (req_valid_i) w_next = c_lookup;
         c_lookup: begin
            if (!w_hit) begin
               w_next = c_refill;
            end else if (!req_valid_i) begin
               w_next = c_idle;
            end
         end
         c_refill: if (w_last) w_next = c_resp;
         c_resp:   w_next = c_idle;
         default:  w_next = c_idle;
      endcase
   end

   always_comb begin
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      mem_req_o   = 1'b0;
      case (r_state)
         c_idle:   req_ready_o = 1'b1;
         c_lookup: begin
            req_ready_o = w_hit;
            rsp_valid_o = w_hit;
         end
         c_refill: mem_req_o = 1'b1;
         c_resp:   rsp_valid_o = 1'b1;
         default:  ;
      endcase
   end

   assign mem_addr_o = mem_req_o ? {w_tag, w_idx, r_cnt, 2'b00} : '0;
   assign rsp_data_o = rsp_valid_o ? r_data[{w_idx, w_off}] : 32'd0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_addr       <= '0;
         r_cnt        <= '0;
         r_flush_pend <= 1'b0;
         r_valid      <= '0;
      end else begin
         if (w_accept) begin
            r_addr <= req_addr_i[ADDR_W-1:2];
         end
         if (w_in_lookup && !w_hit) begin
            r_cnt <= '0;
         end else if (w_mem_done) begin
            r_cnt <= r_cnt + c_off_w'(1);
         end
         if (r_state == c_resp) begin
            r_flush_pend <= 1'b0;
         end else if ((r_state == c_refill) && flush_i) begin
            r_flush_pend <= 1'b1;
         end
         if (w_last) begin
            r_valid[w_idx] <= 1'b1;
         end
         if (w_flush_clr) begin
            r_valid <= '0;
         end
      end
   end

   // Tag and data storage carry no reset so they can map onto RAM.
   always_ff @(posedge clk_i) begin
      if (w_mem_done) begin
         r_data[{w_idx, r_cnt}] <= mem_data_i;
         if (r_cnt == c_last) begin
            r_tag[w_idx] <= w_tag;
         end
      end
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (w_in_lookup) begin
         if (w_hit) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end else begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign hit_cnt_o  = r_hit_cnt;
   assign miss_cnt_o = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_cache_dm.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_cache_dm
// Brief    : Self-checking bench for instr_cache_dm against a line-level
//            reference model; covers ICACHE_PERF_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_cache_dm;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic [31:0] req_addr_i = '0;
   logic        req_ready_o;
   logic        rsp_valid_o;
   logic [31:0] rsp_data_o;
   logic        flush_i = 1'b0;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_valid_i;
   logic [31:0] mem_data_i = '0;
   logic        mv = 1'b0;
   logic        stray_valid = 1'b0;
   logic        mwait = 1'b0;
`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt_o;
   logic [31:0] miss_cnt_o;
`endif

   instr_cache_dm dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_addr_i  (req_addr_i),
      .req_ready_o (req_ready_o),
      .rsp_valid_o (rsp_valid_o),
      .rsp_data_o  (rsp_data_o),
      .flush_i     (flush_i),
      .mem_req_o   (mem_req_o),
      .mem_addr_o  (mem_addr_o),
      .mem_valid_i (mem_valid_i),
      .mem_data_i  (mem_data_i)
`ifdef ICACHE_PERF_EN
     ,.hit_cnt_o   (hit_cnt_o),
      .miss_cnt_o  (miss_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   int          cyc = 0;
   int          n_pass = 0;
   int          n_tot = 0;
   int          last_dec = 0;
   bit          rnd_flush = 1'b0;
   exp_t        exp_rsp[$];
   logic [31:0] exp_mem[$];
   logic [31:0] mem_log[$];
   logic [31:0] rsp_log[$];
   int          rsp_cyc_log[$];

   // Reference model: one valid/tag entry per line; data always equals memory.
   bit          m_valid[64];
   logic [21:0] m_tag[64];
   bit          pf = 1'b0;
   int          pf_cyc = 0;
   int          pf_idx = 0;
   logic [21:0] pf_tag = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail(input string name);
      n_tot++;
      $display("FAIL %s: actual=missing required=present (cycle %0d)", name, cyc);
   endtask

   // Memory: every word takes two cycles of mem_req_o, data = addr ^ 0xA5A50000.
   always @(negedge clk) begin
      mv = 1'b0;
      if (mem_req_o === 1'b1) begin
         if (mwait) begin
            mv         = 1'b1;
            mem_data_i = mem_word(mem_addr_o);
            mem_log.push_back(mem_addr_o);
            mwait      = 1'b0;
         end else begin
            mwait = 1'b1;
         end
      end else begin
         mwait = 1'b0;
      end
   end
   assign mem_valid_i = mv | stray_valid;

   // Compare process: responses and memory addresses against model expectations.
   always @(negedge clk) begin
      #1;
      if (rsp_valid_o === 1'b1) begin
         rsp_log.push_back(rsp_data_o);
         rsp_cyc_log.push_back(cyc);
      end
      if (exp_rsp.size() > 0 && exp_rsp[0].due == cyc) begin
         chk("rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
         chk("rsp_data", rsp_data_o, exp_rsp[0].data);
         void'(exp_rsp.pop_front());
      end else if (rsp_valid_o === 1'b1) begin
         chk("rsp_unexpected", {31'd0, rsp_valid_o}, 32'd0);
      end
      if (mem_req_o === 1'b1) begin
         if (exp_mem.size() == 0) begin
            fail("mem_req_unexpected");
         end else begin
            chk("mem_addr", mem_addr_o, exp_mem[0]);
            if (mem_valid_i) void'(exp_mem.pop_front());
         end
      end
   end

   task automatic model_pre();
      if (pf && cyc >= pf_cyc) begin
         m_valid[pf_idx] = 1'b1;
         m_tag[pf_idx]   = pf_tag;
         pf              = 1'b0;
      end
      if (flush_i) begin
         foreach (m_valid[i]) m_valid[i] = 1'b0;
      end
   endtask

   task automatic predict(input logic [31:0] a);
      int  idx;
      bit  hit;
      exp_t e;
      idx    = int'(a[9:4]);
      hit    = m_valid[idx] && (m_tag[idx] == a[31:10]);
      e.due  = cyc + (hit ? 1 : 10);
      e.data = mem_word({a[31:2], 2'b00});
      exp_rsp.push_back(e);
      if (!hit) begin
         for (int k = 0; k < 4; k++) exp_mem.push_back({a[31:4], 4'b0} + 32'(4 * k));
         pf     = 1'b1;
         pf_cyc = cyc + 2;
         pf_idx = idx;
         pf_tag = a[31:10];
      end
   endtask

   task automatic cyc1(output bit acc);
      model_pre();
      acc = 1'b0;
      if (req_valid_i && req_ready_o === 1'b1) begin
         predict(req_addr_i);
         last_dec = cyc;
         acc      = 1'b1;
      end
      @(negedge clk);
      flush_i = 1'b0;
   endtask

   task automatic issue(input logic [31:0] a);
      bit acc;
      req_valid_i = 1'b1;
      req_addr_i  = a;
      for (int k = 0; k < 64; k++) begin
         if (rnd_flush && $urandom_range(0, 23) == 0) flush_i = 1'b1;
         cyc1(acc);
         if (acc) return;
      end
      fail("accept_timeout");
   endtask

   task automatic idle(input int n);
      bit acc;
      req_valid_i = 1'b0;
      repeat (n) cyc1(acc);
   endtask

   task automatic clear_logs();
      mem_log.delete();
      rsp_log.delete();
      rsp_cyc_log.delete();
   endtask

   task automatic chk_mem(input string name, input int i, input logic [31:0] exp);
      if (mem_log.size() > i) chk(name, mem_log[i], exp);
      else fail(name);
   endtask

   task automatic chk_rsp(input string name, input int i, input logic [31:0] exp);
      if (rsp_log.size() > i) chk(name, rsp_log[i], exp);
      else fail(name);
   endtask

   task automatic chk_lat(input string name, input int i, input int exp);
      if (rsp_cyc_log.size() > i) chk(name, 32'(rsp_cyc_log[i] - last_dec), 32'(exp));
      else fail(name);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit          acc;
      logic [31:0] a;
      int          d;
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      chk("reset_ready", {31'd0, req_ready_o}, 32'd1);
      chk("reset_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      chk("reset_rsp_data", rsp_data_o, 32'd0);
      chk("reset_mem_req", {31'd0, mem_req_o}, 32'd0);
      chk("reset_mem_addr", mem_addr_o, 32'd0);

      // Cold miss: four ordered word reads, response ten cycles after accept.
      clear_logs();
      issue(32'h040);
      idle(14);
      chk("cold_nreads", 32'(mem_log.size()), 32'd4);
      for (int k = 0; k < 4; k++) chk_mem("cold_read", k, 32'h040 + 32'(4 * k));
      chk_rsp("cold_data", 0, 32'hA5A5_0040);
      chk_lat("cold_latency", 0, 10);

      // Back-to-back hits with request held high.
      clear_logs();
      issue(32'h040);
      issue(32'h044);
      issue(32'h04C);
      idle(3);
      chk("b2b_count", 32'(rsp_log.size()), 32'd3);
      chk_rsp("b2b_data0", 0, 32'hA5A5_0040);
      chk_rsp("b2b_data1", 1, 32'hA5A5_0044);
      chk_rsp("b2b_data2", 2, 32'hA5A5_004C);
      if (rsp_cyc_log.size() == 3)
         chk("b2b_consecutive", 32'(rsp_cyc_log[2] - rsp_cyc_log[0]), 32'd2);
      else
         fail("b2b_consecutive");
`ifdef ICACHE_PERF_EN
      chk("perf_hits", hit_cnt_o, 32'd3);
      chk("perf_misses", miss_cnt_o, 32'd1);
`endif

      clear_logs();
      issue(32'h048);
      idle(3);
      chk_rsp("hit_data", 0, 32'hA5A5_0048);
      chk_lat("hit_latency", 0, 1);
      chk("hit_no_mem", 32'(mem_log.size()), 32'd0);

      // Conflict on index 4.
      clear_logs();
      issue(32'h440);
      idle(14);
      chk_mem("conflict_first", 0, 32'h440);
      chk_mem("conflict_last", 3, 32'h44C);
      clear_logs();
      issue(32'h040);
      idle(14);
      chk("refetch_nreads", 32'(mem_log.size()), 32'd4);

      // Flush in IDLE.
      flush_i = 1'b1;
      idle(1);
      clear_logs();
      issue(32'h044);
      idle(14);
      chk("flush_idle_nreads", 32'(mem_log.size()), 32'd4);

      // Flush during refill still delivers the response.
      clear_logs();
      issue(32'h080);
      idle(3);
      flush_i = 1'b1;
      idle(12);
      chk_rsp("flush_refill_data", 0, 32'hA5A5_0080);
      clear_logs();
      issue(32'h080);
      idle(14);
      chk("flush_refill_nreads", 32'(mem_log.size()), 32'd4);

      // Reset after two words of a refill.
      clear_logs();
      issue(32'h100);
      d = last_dec;
      idle(5);
      chk("pre_reset_words", 32'(mem_log.size()), 32'd2);
      rst_i = 1'b1;
      cyc1(acc);
      rst_i = 1'b0;
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      pf = 1'b0;
      exp_rsp.delete();
      exp_mem.delete();
      chk("post_reset_cycle", 32'(cyc - d), 32'd7);
      chk("post_reset_mem_req", {31'd0, mem_req_o}, 32'd0);
      chk("post_reset_ready", {31'd0, req_ready_o}, 32'd1);
`ifdef ICACHE_PERF_EN
      chk("post_reset_hits", hit_cnt_o, 32'd0);
      chk("post_reset_misses", miss_cnt_o, 32'd0);
`endif
      stray_valid = 1'b1;
      cyc1(acc);
      stray_valid = 1'b0;
      clear_logs();
      issue(32'h100);
      idle(14);
      chk("reset_refill_nreads", 32'(mem_log.size()), 32'd4);
      chk_mem("reset_refill_first", 0, 32'h100);
      chk_mem("reset_refill_last", 3, 32'h10C);
      chk_rsp("reset_refill_data", 0, 32'hA5A5_0100);

      // Randomized traffic over a small address pool with random flushes.
      rnd_flush = 1'b1;
      repeat (300) begin
         a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) flush_i = 1'b1;
         issue(a);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      rnd_flush = 1'b0;
      idle(16);
      chk("rsp_drained", 32'(exp_rsp.size()), 32'd0);
      chk("mem_drained", 32'(exp_mem.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
`default_nettype wire
